display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display on the board. It holds a 32-bit display value and steps through the digits at a fixed refresh rate. For each digit it drives the active-low anode vector and the 4-bit nibble feeding the seven-segment decoder. It also drives that decoder's `dec_trigger` mode input and blanks leading zeros. Updates are double-buffered and applied only at frame boundaries, so the display never shows a torn value.

## Interface

- `REFRESH_DIV`, default 100000: clock cycles per digit slot; 1 kHz per digit at 100 MHz. Legal range ≥ 2.
- `N_DIGITS`, default 8: number of scanned digits. Legal range 1..8.

- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `value`  in  32  display value, nibble k goes to digit k; digit 0 is the rightmost.
- `mode_bcd`  in  1  mode captured with `value`: 1 = BCD (decoder shows 0–9, blanks 10–15), 0 = HEX.
- `blank_lz`  in  1  leading-zero blank enable, captured with `value`.
- `load`  in  1  single-cycle strobe that captures `value`, `mode_bcd` and `blank_lz`.
- `AN`  out  8  digit anodes, active low; bits ≥ `N_DIGITS` are always 1.
- `dig_nibble`  out  4  nibble for the digit currently enabled; goes to the decoder `in`.
- `dec_trigger`  out  1  decoder mode select, equal to the active `mode_bcd`.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.
- `load_pending`  out  1  high while a captured value is waiting for the next frame boundary.

## Operation

- Prescaler `pcnt` counts 0..`REFRESH_DIV`-1 and wraps. `tick` = (`pcnt` == `REFRESH_DIV`-1).
- Digit index `idx` advances on each `tick`, wrapping from `N_DIGITS`-1 to 0.
- **Frame boundary:** a `tick` while `idx` == `N_DIGITS`-1.
- Register sets:
  - **Pending set:** `pend_val`, `pend_bcd`, `pend_lz`, plus flag `pend_v`.
  - **Active set:** `act_val`, `act_bcd`, `act_lz`, plus 8-bit `blank_mask`.
- `load` outside a frame boundary:
  - Captures the inputs into the pending set and sets `pend_v`.
  - A later `load` before the boundary overwrites the pending set; the last one wins.
- At a frame boundary:
  - If `load` is high in the same cycle, the active set takes the inputs directly (bypass).
  - Otherwise, if `pend_v` is set, the active set takes the pending set.
  - Otherwise the active set is unchanged.
  - `pend_v` clears in every case.
- `blank_mask` is computed from the newly selected value whenever the active set updates:
  - If `lz` = 1, bit k = 1 for every digit k above the highest non-zero nibble.
  - Digit 0 is never blanked; a value of 0 shows a single "0".
  - If `lz` = 0, the mask is all zeros.
- Registered outputs, updated on each `tick` using the next `idx` and the next active set:
  - `AN`: bit `idx` is 0 unless masked; all other bits are 1.
  - `dig_nibble` = `act_val`[4·idx+3 : 4·idx].
  - `dec_trigger` = `act_bcd`.
- Out-of-range nibbles in BCD mode are passed through unchanged; the decoder blanks them.

## Timing

- Reset values (asynchronous):
  - `AN` = 8'hFF, `dig_nibble` = 0, `dec_trigger` = 0.
  - `frame_done` = 0, `load_pending` = 0.
  - `pcnt` = 0, `idx` = `N_DIGITS`-1, so the first tick selects digit 0.
  - Both register sets = 0, `blank_mask` = 0.
- Display start-up:
  - The first anode goes low (`AN`[0]) `REFRESH_DIV` cycles after `reset` deasserts.
  - That first tick is itself a frame boundary, so a `load` issued before it takes effect immediately.
- Each digit stays enabled for exactly `REFRESH_DIV` cycles; one frame = `N_DIGITS`·`REFRESH_DIV` cycles.
- `AN`, `dig_nibble` and `dec_trigger` change in the same cycle; there is no intermediate glitch state.
- `frame_done` is registered: it is high the cycle after the boundary tick, for 1 cycle.
- `load_pending`:
  - Goes high the cycle after a non-boundary `load`.
  - Goes low the cycle after the boundary.
- Update latency:
  - The new value is visible starting at digit 0 of the frame that follows the boundary.
  - Worst-case load-to-display latency is `N_DIGITS`·`REFRESH_DIV` cycles.
- `reset` asserted mid-frame forces all reset values immediately; a pending load is discarded.

## Test plan

- Reset and scan, `REFRESH_DIV`=4, `N_DIGITS`=8, no load:
  - `AN` = FF for 4 cycles after reset release.
  - Then FE, FD, FB, … 7F, FE, each held for 4 cycles; `dig_nibble` = 0 throughout.
  - `frame_done` pulses every 32 cycles.
- Load mid-frame: `load` with `value`=32'h1234ABCD, `mode_bcd`=0 while digit 3 is active.
  - `load_pending` = 1 until the boundary.
  - Digits 4–7 of the current frame still show the old value.
  - The next frame shows nibbles D, C, B, A, 4, 3, 2, 1 on digits 0..7.
- Leading-zero blanking: `value`=32'h00000305, `blank_lz`=1.
  - Digits 0–2 are enabled in turn.
  - Digit slots 3–7 hold `AN` = FF for their full 4 cycles.
  - `value`=0 with `blank_lz`=1 shows only digit 0, with nibble 0.
- Simultaneous load at the boundary, with a pending value 32'h11111111:
  - `load` with 32'h22222222 in the boundary tick cycle.
  - The next frame shows 2s; `load_pending` ends at 0.
- BCD mode: `value`=32'h000000A9, `mode_bcd`=1, `blank_lz`=0.
  - `dec_trigger` = 1.
  - Digit 0 nibble = 9, digit 1 nibble = A (the decoder blanks it), digits 2–7 nibble = 0.
- Reset mid-operation: assert `reset` while `load_pending`=1 and digit 5 is active.
  - `AN` = FF and `load_pending` = 0 immediately.
  - After release, the display shows 0s; the discarded value never appears.

Source files
------------

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : 8-digit seven-segment scan controller with double-buffered,
//            frame-aligned updates and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int N_DIGITS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        mode_bcd,
    input  logic        blank_lz,
    input  logic        load,
    output logic [7:0]  AN,
    output logic [3:0]  dig_nibble,
    output logic        dec_trigger,
    output logic        frame_done,
    output logic        load_pending
);

    localparam int              c_PW   = $clog2(REFRESH_DIV);
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(REFRESH_DIV - 1);
    localparam logic [2:0]      c_LAST = 3'(N_DIGITS - 1);

    logic [c_PW-1:0] r_pcnt;
    logic [2:0]      r_idx;
    logic [31:0]     r_pend_val;
    logic            r_pend_bcd;
    logic            r_pend_lz;
    logic            r_pend_v;
    logic [31:0]     r_act_val;
    logic            r_act_bcd;
    logic            r_act_lz;
    logic [7:0]      r_blank_mask;

    logic            w_tick;
    logic            w_boundary;
    logic [2:0]      w_idx_nxt;
    logic [31:0]     w_nxt_val;
    logic            w_nxt_bcd;
    logic            w_nxt_lz;
    logic [7:0]      w_nxt_mask;
    logic [7:0]      w_mask_calc;
    logic            w_seen;
    logic [7:0]      w_an;

    assign w_tick     = (r_pcnt == c_PMAX);
    assign w_boundary = w_tick && (r_idx == c_LAST);
    assign w_idx_nxt  = (r_idx == c_LAST) ? 3'd0 : r_idx + 3'd1;

    // Active-set source at a boundary: same-cycle load bypasses the pending set.
    always_comb begin
        w_nxt_val = r_act_val;
        w_nxt_bcd = r_act_bcd;
        w_nxt_lz  = r_act_lz;
        if (w_boundary) begin
            if (load) begin
                w_nxt_val = value;
                w_nxt_bcd = mode_bcd;
                w_nxt_lz  = blank_lz;
            end else if (r_pend_v) begin
                w_nxt_val = r_pend_val;
                w_nxt_bcd = r_pend_bcd;
                w_nxt_lz  = r_pend_lz;
            end
        end
    end

    // Digits above the highest non-zero nibble are blanked; digit 0 never is.
    always_comb begin
        w_seen      = 1'b0;
        w_mask_calc = 8'h00;
        for (int k = 7; k >= 1; k--) begin
            if (w_nxt_val[4*k +: 4] != 4'd0) begin
                w_seen = 1'b1;
            end
            w_mask_calc[k] = w_nxt_lz & ~w_seen;
        end
    end

    assign w_nxt_mask = w_boundary ? w_mask_calc : r_blank_mask;

    always_comb begin
        w_an = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if ((k < N_DIGITS) && (3'(k) == w_idx_nxt) && !w_nxt_mask[k]) begin
                w_an[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt       <= '0;
            r_idx        <= c_LAST;
            r_pend_val   <= 32'd0;
            r_pend_bcd   <= 1'b0;
            r_pend_lz    <= 1'b0;
            r_pend_v     <= 1'b0;
            r_act_val    <= 32'd0;
            r_act_bcd    <= 1'b0;
            r_act_lz     <= 1'b0;
            r_blank_mask <= 8'h00;
            AN           <= 8'hFF;
            dig_nibble   <= 4'd0;
            dec_trigger  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            r_pcnt     <= w_tick ? '0 : r_pcnt + 1'b1;
            frame_done <= w_boundary;
            if (w_tick) begin
                r_idx       <= w_idx_nxt;
                AN          <= w_an;
                dig_nibble  <= w_nxt_val[{w_idx_nxt, 2'b00} +: 4];
                dec_trigger <= w_nxt_bcd;
            end
            if (w_boundary) begin
                r_act_val    <= w_nxt_val;
                r_act_bcd    <= w_nxt_bcd;
                r_act_lz     <= w_nxt_lz;
                r_blank_mask <= w_mask_calc;
                r_pend_v     <= 1'b0;
            end else if (load) begin
                r_pend_val <= value;
                r_pend_bcd <= mode_bcd;
                r_pend_lz  <= blank_lz;
                r_pend_v   <= 1'b1;
            end
        end
    end

    assign load_pending = r_pend_v;

endmodule
`default_nettype wire
